vx_fp_rsp_buffer: RTL and testbench

VX_FP_RSP_BUFFER -- requirements
Module: VX_fp_rsp_buffer

---
 rtl/vx_fp_rsp_buffer.sv | 92 +++++++++
 tb/tb_vx_fp_rsp_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vx_fp_rsp_buffer.sv
// In-order response buffer between the FP FMA pipeline and commit; flags are lane-merged on entry.
// Latency 1 push-to-output; ready_in depends only on reset and occupancy, outputs come from storage only.
module vx_fp_rsp_buffer #(
  parameter int TAGW  = 1,
  parameter int LANES = 1,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [TAGW-1:0]       tag_in,
  input  logic [LANES*32-1:0]   result_in,
  input  logic                  has_fflags_in,
  input  logic [LANES*5-1:0]    fflags_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [TAGW-1:0]       tag_out,
  output logic [LANES*32-1:0]   result_out,
  output logic                  has_fflags_out,
  output logic [4:0]            fflags_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [TAGW-1:0]     tag_mem [DEPTH];
  logic [LANES*32-1:0] res_mem [DEPTH];
  logic                has_mem [DEPTH];
  logic [4:0]          ff_mem  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          push;
  logic          pop;
  logic [4:0]    ff_merged;

  assign ready_in  = ~reset & (cnt != FULL);
  assign valid_out = (cnt != '0);
  assign push      = valid_in & ready_in;
  assign pop       = valid_out & ready_out;
  assign count     = cnt;

  // Only the lane-OR of the flags is kept; per-lane detail is not needed at commit.
  always_comb begin
    ff_merged = '0;
    for (int l = 0; l < LANES; l++) begin
      ff_merged = ff_merged | fflags_in[l*5 +: 5];
    end
    if (!has_fflags_in) begin
      ff_merged = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= tag_in;
      res_mem[wr_ptr] <= result_in;
      has_mem[wr_ptr] <= has_fflags_in;
      ff_mem[wr_ptr]  <= ff_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Flag outputs are masked by occupancy so an empty buffer never shows stale flags.
  assign tag_out        = tag_mem[rd_ptr];
  assign result_out     = res_mem[rd_ptr];
  assign has_fflags_out = valid_out & has_mem[rd_ptr];
  assign fflags_out     = valid_out ? ff_mem[rd_ptr] : 5'b0;

endmodule

// File: tb/tb_vx_fp_rsp_buffer.sv
// Scoreboard bench for vx_fp_rsp_buffer (LANES=2, TAGW=4, DEPTH=4) against a queue reference model.
module tb_vx_fp_rsp_buffer;

  typedef struct packed {
    logic [3:0]  tag;
    logic [63:0] res;
    logic        has;
    logic [4:0]  ff;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [3:0]  tag_in;
  logic [63:0] result_in;
  logic        has_fflags_in;
  logic [9:0]  fflags_in;
  logic        valid_out;
  logic        ready_out;
  logic [3:0]  tag_out;
  logic [63:0] result_out;
  logic        has_fflags_out;
  logic [4:0]  fflags_out;
  logic [2:0]  count;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  ent_t mq[$];

  vx_fp_rsp_buffer #(.TAGW(4), .LANES(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in),
    .tag_in(tag_in), .result_in(result_in),
    .has_fflags_in(has_fflags_in), .fflags_in(fflags_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .tag_out(tag_out), .result_out(result_out),
    .has_fflags_out(has_fflags_out), .fflags_out(fflags_out),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected entry derived from the input rules with plain arithmetic.
  function automatic ent_t mk_entry();
    ent_t e;
    e.tag = tag_in;
    e.res = result_in;
    e.has = has_fflags_in;
    e.ff  = has_fflags_in ? (fflags_in[4:0] | fflags_in[9:5]) : 5'b0;
    return e;
  endfunction

  // Monitor: checks DUT against model mid-cycle, then advances the model for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int   sz;
      bit   acc;
      bit   popv;
      ent_t e;
      sz = mq.size();
      chk("count", 64'(count), 64'(sz));
      chk("ready_in", 64'(ready_in), 64'(!reset && sz < 4));
      chk("valid_out", 64'(valid_out), 64'(sz != 0));
      if (sz != 0) begin
        chk("tag_out", 64'(tag_out), 64'(mq[0].tag));
        chk("result_out", result_out, mq[0].res);
        chk("has_fflags_out", 64'(has_fflags_out), 64'(mq[0].has));
        chk("fflags_out", 64'(fflags_out), 64'(mq[0].ff));
      end else begin
        chk("empty_has_fflags", 64'(has_fflags_out), 64'd0);
        chk("empty_fflags", 64'(fflags_out), 64'd0);
      end
      if (reset) begin
        mq.delete();
      end else begin
        acc  = valid_in && (sz < 4);
        popv = (sz != 0) && ready_out;
        e    = mk_entry();
        if (popv) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit vi, input logic [3:0] t, input logic [63:0] r,
                       input bit h, input logic [9:0] f, input bit ro);
    valid_in      = vi;
    tag_in        = t;
    result_in     = r;
    has_fflags_in = h;
    fflags_in     = f;
    ready_out     = ro;
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    while ((count != 3'd0 || mq.size() != 0) && n < 50) begin
      step();
      n++;
    end
    chk("drain_done", 64'(count), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    valid_in = 1'b0; tag_in = '0; result_in = '0;
    has_fflags_in = 1'b0; fflags_in = '0; ready_out = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;

    // Single push, immediate commit.
    drive(1, 4'd3, {32'h4000_0000, 32'h3f80_0000}, 0, 10'd0, 1);
    drive(0, 4'd0, 64'd0, 0, 10'd0, 1);
    drive(0, 4'd0, 64'd0, 0, 10'd0, 1);

    // Fill to full, a fifth push must be dropped, then drain in order.
    for (int i = 1; i <= 4; i++) drive(1, 4'(i), 64'(i * 32'h1111_1111), 0, 10'd0, 0);
    drive(1, 4'd5, 64'hdead_beef, 0, 10'd0, 0);
    drive(1, 4'd5, 64'hdead_beef, 0, 10'd0, 0);
    for (int i = 0; i < 6; i++) drive(0, 4'd0, 64'd0, 0, 10'd0, 1);

    // Hold two entries, then ten cycles of simultaneous push and pop.
    drive(1, 4'd6, 64'h6, 0, 10'd0, 0);
    drive(1, 4'd7, 64'h7, 0, 10'd0, 0);
    for (int i = 0; i < 10; i++) drive(1, 4'(8 + i), 64'(100 + i), 1, 10'(i), 1);
    drain();

    // Flag merge with and without has_fflags.
    drive(1, 4'd9, 64'h1, 1, {5'b00001, 5'b10000}, 0);
    drive(1, 4'd10, 64'h2, 0, {5'b00001, 5'b10000}, 0);
    drain();

    // Reset while holding three entries.
    for (int i = 0; i < 3; i++) drive(1, 4'(11 + i), 64'(i), 1, 10'h3ff, 0);
    valid_in = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 4'd0, 64'd0, 0, 10'd0, 0);
    drive(0, 4'd0, 64'd0, 0, 10'd0, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    @(negedge clk);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
